// File: rtl/seg7_decoder_if.sv
// seg7_decoder_if: digit-level signal bundle for one seven-segment digit.
// master = the side supplying the digit value and controls (display controller),
// slave  = the decoder itself.
interface seg7_decoder_if;
  logic [3:0] bcd;
  logic       lamp_test;
  logic       blank;
  logic       rbi;
  logic       rbo;
  logic [6:0] leds;

  modport master (
    output bcd,
    output lamp_test,
    output blank,
    output rbi,
    input  rbo,
    input  leds
  );

  modport slave (
    input  bcd,
    input  lamp_test,
    input  blank,
    input  rbi,
    output rbo,
    output leds
  );
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: single-digit BCD to seven-segment decoder with ripple blanking.
// Segment order on leds[6:0] is {g,f,e,d,c,b,a}.
// Optional macro SEG7_DECODER_HEX_DIGITS_EN: codes 10..15 show A,b,C,d,E,F
// instead of the blank pattern.
// Internally every pattern is built active-low (0 = lit) and only inverted at
// the output when ACTIVE_LOW_SEGS is 0, so the reset value of the register is
// always "all dark" regardless of polarity.
module seg7_decoder #(
  parameter int unsigned ACTIVE_LOW_SEGS = 1,
  parameter int unsigned REG_OUT         = 1
) (
  input  logic          clk,
  input  logic          reset,
  seg7_decoder_if.slave bus
);

  localparam logic [6:0] SEG_DARK = 7'b1111111;
  localparam logic [6:0] SEG_LIT  = 7'b0000000;

  logic [6:0] glyph_n;
  logic [6:0] seg_n;
  logic [6:0] leds_n;
  logic       ripple_zero;

  // Ripple-blank out: pure function of rbi and bcd, unaffected by overrides or reset.
  assign ripple_zero = bus.rbi && (bus.bcd == 4'd0);
  assign bus.rbo     = ripple_zero;

  // Glyph lookup for the digit value, active-low.
  always_comb begin
    glyph_n = SEG_DARK;
    case (bus.bcd)
      4'd0:    glyph_n = 7'b1000000;
      4'd1:    glyph_n = 7'b1111001;
      4'd2:    glyph_n = 7'b0100100;
      4'd3:    glyph_n = 7'b0110000;
      4'd4:    glyph_n = 7'b0011001;
      4'd5:    glyph_n = 7'b0010010;
      4'd6:    glyph_n = 7'b0000010;
      4'd7:    glyph_n = 7'b1111000;
      4'd8:    glyph_n = 7'b0000000;
      4'd9:    glyph_n = 7'b0010000;
`ifdef SEG7_DECODER_HEX_DIGITS_EN
      4'd10:   glyph_n = 7'b0001000;
      4'd11:   glyph_n = 7'b0000011;
      4'd12:   glyph_n = 7'b1000110;
      4'd13:   glyph_n = 7'b0100001;
      4'd14:   glyph_n = 7'b0000110;
      4'd15:   glyph_n = 7'b0001110;
`endif
      default: glyph_n = SEG_DARK;
    endcase
  end

  // Override priority: lamp test beats blank beats ripple blank beats the glyph.
  always_comb begin
    seg_n = glyph_n;
    if (bus.lamp_test)
      seg_n = SEG_LIT;
    else if (bus.blank)
      seg_n = SEG_DARK;
    else if (ripple_zero)
      seg_n = SEG_DARK;
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [6:0] seg_q;

      // Output register; reset forces the display dark immediately.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          seg_q <= SEG_DARK;
        else
          seg_q <= seg_n;
      end

      assign leds_n = seg_q;
    end else begin : g_comb
      assign leds_n = seg_n;
    end
  endgenerate

  assign bus.leds = (ACTIVE_LOW_SEGS != 0) ? leds_n : ~leds_n;

endmodule

// File: tb/tb_seg7_decoder.sv
// tb_seg7_decoder: six-digit display chain (HEX5 = most significant digit,
// HEX0 = ones digit with rbi tied 0) exercised with directed vectors.
module tb_seg7_decoder;

  logic       clk;
  logic       reset;
  logic [3:0] digit_bcd [6];
  logic       lamp_test;
  logic       blank;
  logic       rbi_top;
  logic [6:0] leds_w [6];
  logic       rbo_w [6];

  int checks;
  int failures;

  seg7_decoder_if dig_if [6] ();

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_dig
      assign dig_if[gi].bcd       = digit_bcd[gi];
      assign dig_if[gi].lamp_test = lamp_test;
      assign dig_if[gi].blank     = blank;
      if (gi == 5) begin : g_top
        assign dig_if[gi].rbi = rbi_top;
      end else if (gi == 0) begin : g_ones
        assign dig_if[gi].rbi = 1'b0;
      end else begin : g_mid
        assign dig_if[gi].rbi = dig_if[gi+1].rbo;
      end
      assign leds_w[gi] = dig_if[gi].leds;
      assign rbo_w[gi]  = dig_if[gi].rbo;

      seg7_decoder #(.ACTIVE_LOW_SEGS(1), .REG_OUT(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dig_if[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] DARK = 7'b1111111;
  localparam logic [6:0] LIT  = 7'b0000000;

  // Hand-written decode table, active-low {g,f,e,d,c,b,a}.
  logic [6:0] exp_digit [10];
  logic [6:0] exp_hex   [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    digit_bcd[5] = 4'd8;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (leds_w[i] !== DARK) begin
        failures++;
        $display("FAIL reset_blank digit=%0d got=%b want=%b", i, leds_w[i], DARK);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (leds_w[5] !== DARK) begin
      failures++;
      $display("FAIL reset_hold got=%b want=%b", leds_w[5], DARK);
    end
    tick();
    checks++;
    if (leds_w[5] !== 7'b0000000) begin
      failures++;
      $display("FAIL reset_release_8 got=%b want=%b", leds_w[5], 7'b0000000);
    end
  endtask

  task automatic test_sweep();
    logic [6:0] prev;
    prev = 7'b0000000;
    for (int v = 0; v <= 9; v++) begin
      digit_bcd[5] = v[3:0];
      #1;
      checks++;
      if (leds_w[5] !== prev) begin
        failures++;
        $display("FAIL sweep_latency bcd=%0d got=%b want=%b", v, leds_w[5], prev);
      end
      checks++;
      if (rbo_w[5] !== 1'b0) begin
        failures++;
        $display("FAIL sweep_rbo bcd=%0d got=%b want=0", v, rbo_w[5]);
      end
      tick();
      checks++;
      if (leds_w[5] !== exp_digit[v]) begin
        failures++;
        $display("FAIL sweep_decode bcd=%0d got=%b want=%b", v, leds_w[5], exp_digit[v]);
      end
      prev = exp_digit[v];
    end
  endtask

  task automatic test_overrides();
    digit_bcd[5] = 4'd5;
    blank = 1'b1;
    tick();
    checks++;
    if (leds_w[5] !== DARK) begin
      failures++;
      $display("FAIL override_blank got=%b want=%b", leds_w[5], DARK);
    end
    lamp_test = 1'b1;
    tick();
    checks++;
    if (leds_w[5] !== LIT) begin
      failures++;
      $display("FAIL override_lamp_and_blank got=%b want=%b", leds_w[5], LIT);
    end
    blank = 1'b0;
    tick();
    checks++;
    if (leds_w[5] !== LIT) begin
      failures++;
      $display("FAIL override_lamp_only got=%b want=%b", leds_w[5], LIT);
    end
    // Lamp test also wins over ripple blanking.
    rbi_top = 1'b1;
    digit_bcd[5] = 4'd0;
    tick();
    checks++;
    if (leds_w[5] !== LIT) begin
      failures++;
      $display("FAIL override_lamp_ripple got=%b want=%b", leds_w[5], LIT);
    end
    checks++;
    if (rbo_w[5] !== 1'b1) begin
      failures++;
      $display("FAIL override_rbo_lamp got=%b want=1", rbo_w[5]);
    end
    rbi_top = 1'b0;
    digit_bcd[5] = 4'd5;
    lamp_test = 1'b0;
    tick();
    checks++;
    if (leds_w[5] !== 7'b0010010) begin
      failures++;
      $display("FAIL override_release got=%b want=%b", leds_w[5], 7'b0010010);
    end
  endtask

  task automatic test_invalid();
    logic [6:0] want;
    for (int v = 10; v <= 15; v++) begin
      digit_bcd[5] = v[3:0];
      rbi_top = 1'b1;
      tick();
`ifdef SEG7_DECODER_HEX_DIGITS_EN
      want = exp_hex[v-10];
`else
      want = DARK;
`endif
      checks++;
      if (leds_w[5] !== want) begin
        failures++;
        $display("FAIL invalid_code bcd=%0d got=%b want=%b", v, leds_w[5], want);
      end
      checks++;
      if (rbo_w[5] !== 1'b0) begin
        failures++;
        $display("FAIL invalid_rbo bcd=%0d got=%b want=0", v, rbo_w[5]);
      end
    end
    rbi_top = 1'b0;
  endtask

  task automatic test_ripple();
    logic [6:0] want [6];
    // Score 2954 with suppression: digits 0,0,2,9,5,4.
    rbi_top = 1'b1;
    digit_bcd[5] = 4'd0; digit_bcd[4] = 4'd0; digit_bcd[3] = 4'd2;
    digit_bcd[2] = 4'd9; digit_bcd[1] = 4'd5; digit_bcd[0] = 4'd4;
    #1;
    checks++;
    if (rbo_w[5] !== 1'b1 || rbo_w[4] !== 1'b1 || rbo_w[3] !== 1'b0) begin
      failures++;
      $display("FAIL ripple_rbo_chain got=%b%b%b want=110", rbo_w[5], rbo_w[4], rbo_w[3]);
    end
    tick();
    want[5] = DARK; want[4] = DARK; want[3] = 7'b0100100;
    want[2] = 7'b0010000; want[1] = 7'b0010010; want[0] = 7'b0011001;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (leds_w[i] !== want[i]) begin
        failures++;
        $display("FAIL ripple_2954 hex%0d got=%b want=%b", i, leds_w[i], want[i]);
      end
    end
    // Score 0: only HEX0 shows "0".
    for (int i = 0; i < 6; i++) digit_bcd[i] = 4'd0;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (leds_w[i] !== ((i == 0) ? 7'b1000000 : DARK)) begin
        failures++;
        $display("FAIL ripple_zero hex%0d got=%b want=%b", i, leds_w[i],
                 (i == 0) ? 7'b1000000 : DARK);
      end
    end
    // Suppression off: leading zeros show.
    rbi_top = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (leds_w[i] !== 7'b1000000) begin
        failures++;
        $display("FAIL ripple_off hex%0d got=%b want=%b", i, leds_w[i], 7'b1000000);
      end
    end
  endtask

  task automatic test_async_reset();
    digit_bcd[5] = 4'd9;
    rbi_top = 1'b0;
    tick();
    checks++;
    if (leds_w[5] !== 7'b0010000) begin
      failures++;
      $display("FAIL async_pre got=%b want=%b", leds_w[5], 7'b0010000);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (leds_w[5] !== DARK) begin
      failures++;
      $display("FAIL async_assert got=%b want=%b", leds_w[5], DARK);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (leds_w[5] !== DARK) begin
      failures++;
      $display("FAIL async_hold got=%b want=%b", leds_w[5], DARK);
    end
    tick();
    checks++;
    if (leds_w[5] !== 7'b0010000) begin
      failures++;
      $display("FAIL async_release got=%b want=%b", leds_w[5], 7'b0010000);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_digit[0] = 7'b1000000; exp_digit[1] = 7'b1111001;
    exp_digit[2] = 7'b0100100; exp_digit[3] = 7'b0110000;
    exp_digit[4] = 7'b0011001; exp_digit[5] = 7'b0010010;
    exp_digit[6] = 7'b0000010; exp_digit[7] = 7'b1111000;
    exp_digit[8] = 7'b0000000; exp_digit[9] = 7'b0010000;
    exp_hex[0] = 7'b0001000; exp_hex[1] = 7'b0000011;
    exp_hex[2] = 7'b1000110; exp_hex[3] = 7'b0100001;
    exp_hex[4] = 7'b0000110; exp_hex[5] = 7'b0001110;
    for (int i = 0; i < 6; i++) digit_bcd[i] = 4'd0;
    lamp_test = 1'b0;
    blank = 1'b0;
    rbi_top = 1'b0;
    reset = 1'b1;
    #2;
    test_reset();
    test_sweep();
    test_overrides();
    test_invalid();
    test_ripple();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
